// File: rtl/picorv32_pcpi_issue.sv
// picorv32_pcpi_issue: issues one instruction at a time onto PCPI and returns the result or a trap on timeout
// Outputs decode from state or come from registers, so no pcpi_* input reaches an output combinationally.
module picorv32_pcpi_issue #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       accept, expired;

    always_comb begin
        accept    = state == IDLE && req_valid;
        expired   = !pcpi_wait && cnt == 8'(TIMEOUT_CYCLES - 1);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = (pcpi_ready || expired) ? RESP : ISSUE;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // reset gates req_ready so the core sees no acceptance while reset is held
    assign req_ready  = state == IDLE && !reset;
    assign pcpi_valid = state == ISSUE;
    assign rsp_valid  = state == RESP;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pcpi_insn <= '0;
            pcpi_rs1  <= '0;
            pcpi_rs2  <= '0;
            rsp_wr    <= 1'b0;
            rsp_rd    <= '0;
            rsp_trap  <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            pcpi_insn <= req_insn;
            pcpi_rs1  <= req_rs1;
            pcpi_rs2  <= req_rs2;
        end else if (state == ISSUE) begin
            if (pcpi_ready) begin
                rsp_wr   <= pcpi_wr;
                rsp_rd   <= pcpi_rd;
                rsp_trap <= 1'b0;
            end else if (pcpi_wait) begin
                cnt <= '0;
            end else if (expired) begin
                rsp_wr   <= 1'b0;
                rsp_rd   <= '0;
                rsp_trap <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_picorv32_pcpi_issue.sv
// tb_picorv32_pcpi_issue: directed vectors against hand-computed PCPI issue timing and results
module tb_picorv32_pcpi_issue;
    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_trap;
    logic [31:0] rsp_rd;
    logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;
    int          errors = 0;
    int          checks = 0;

    picorv32_pcpi_issue #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_trap(rsp_trap),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        check({tag, " req_ready"}, 32'(req_ready), 1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        tick;
        req_valid = 1'b0;
        req_insn  = 32'h0;
        req_rs1   = 32'h0;
        req_rs2   = 32'h0;
        check({tag, " pcpi_valid"}, 32'(pcpi_valid), 1);
        check({tag, " pcpi_insn"}, pcpi_insn, insn);
        check({tag, " pcpi_rs1"}, pcpi_rs1, rs1);
        check({tag, " pcpi_rs2"}, pcpi_rs2, rs2);
    endtask

    // responder: wait in cycles 1..waits of pcpi_valid, ready in cycle rdy (0 = never)
    task automatic respond(input int rdy, input int waits, input logic wr, input logic [31:0] rd, output int cycles);
        cycles = 0;
        while (pcpi_valid && cycles < 200) begin
            cycles++;
            pcpi_wait  = cycles <= waits;
            pcpi_ready = cycles == rdy;
            pcpi_wr    = wr;
            pcpi_rd    = rd;
            tick;
        end
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'h0;
    endtask

    task automatic op(input string tag, input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                      input int rdy, input int waits, input logic wr, input logic [31:0] rd,
                      input int exp_cycles, input logic exp_trap, input logic exp_wr, input logic [31:0] exp_rd);
        int cycles;
        issue(tag, insn, rs1, rs2);
        respond(rdy, waits, wr, rd, cycles);
        check({tag, " valid_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 1);
        check({tag, " rsp_trap"}, 32'(rsp_trap), 32'(exp_trap));
        check({tag, " rsp_wr"}, 32'(rsp_wr), 32'(exp_wr));
        check({tag, " rsp_rd"}, rsp_rd, exp_rd);
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, " rsp_done"}, 32'(rsp_valid), 0);
        check({tag, " req_ready_after"}, 32'(req_ready), 1);
    endtask

    initial begin
        int cycles;
        reset = 1'b1;
        {req_valid, rsp_ready, pcpi_wr, pcpi_wait, pcpi_ready} = '0;
        {req_insn, req_rs1, req_rs2, pcpi_rd} = '0;
        #1;
        check("rst req_ready", 32'(req_ready), 0);
        check("rst pcpi_valid", 32'(pcpi_valid), 0);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("post_rst req_ready", 32'(req_ready), 1);

        op("mul", 32'h02B50533, 32'd7, 32'd6, 3, 0, 1'b1, 32'd42, 3, 1'b0, 1'b1, 32'd42);
        finish_rsp("mul");

        op("timeout", 32'h0000000B, 32'h11, 32'h22, 0, 0, 1'b1, 32'h5555AAAA, 16, 1'b1, 1'b0, 32'h0);
        finish_rsp("timeout");

        op("wait40", 32'h0200000B, 32'h1, 32'h2, 41, 40, 1'b1, 32'hDEADBEEF, 41, 1'b0, 1'b1, 32'hDEADBEEF);
        finish_rsp("wait40");

        op("wait_drop", 32'h0400000B, 32'h3, 32'h4, 0, 10, 1'b1, 32'h12345678, 26, 1'b1, 1'b0, 32'h0);
        finish_rsp("wait_drop");

        op("ready_at_limit", 32'h0600000B, 32'h5, 32'h6, 16, 0, 1'b0, 32'hCAFEF00D, 16, 1'b0, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp rsp_valid", 32'(rsp_valid), 1);
            check("bp rsp_rd", rsp_rd, 32'hCAFEF00D);
            check("bp rsp_trap", 32'(rsp_trap), 0);
            check("bp req_ready", 32'(req_ready), 0);
        end
        finish_rsp("bp");

        op("b2b_a", 32'h02C58633, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 1'b1, 32'h00000001, 1, 1'b0, 1'b1, 32'h1);
        finish_rsp("b2b_a");
        op("b2b_b", 32'h02D686B3, 32'hC3C3C3C3, 32'hD4D4D4D4, 2, 0, 1'b1, 32'h00000002, 2, 1'b0, 1'b1, 32'h2);
        finish_rsp("b2b_b");
        tick;
        check("b2b no_reissue", 32'(pcpi_valid), 0);

        issue("rst_mid", 32'h02B50533, 32'h9, 32'h8);
        tick;
        reset = 1'b1;
        #1;
        check("rst_mid pcpi_valid", 32'(pcpi_valid), 0);
        check("rst_mid req_ready", 32'(req_ready), 0);
        check("rst_mid pcpi_insn", pcpi_insn, 0);
        check("rst_mid rsp_rd", rsp_rd, 0);
        tick;
        reset = 1'b0;
        #1;
        check("rst_mid req_ready_after", 32'(req_ready), 1);
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h77;
        tick;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        check("late_ready rsp_valid", 32'(rsp_valid), 0);
        check("late_ready rsp_rd", rsp_rd, 0);
        check("late_ready req_ready", 32'(req_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/picorv32_pcpi_issue.md
# picorv32_pcpi_issue

PCPI initiator: accepts one coprocessor instruction at a time from the core's execute stage and drives it onto the PCPI bus (`pcpi_valid`, `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2`). It then collects `pcpi_wr`/`pcpi_rd` from whichever responder asserts `pcpi_ready`, for example the fast multiplier. If no responder claims the instruction within a cycle budget, it returns an illegal-instruction trap. It sits between the core's decode/execute logic and all PCPI coprocessors, and it owns the bus-side timeout.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum `pcpi_valid` cycles without `pcpi_ready`/`pcpi_wait` before trapping; legal range 2..255.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core offers an instruction.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_insn`  in  32  instruction word.
- `req_rs1`  in  32  operand 1.
- `req_rs2`  in  32  operand 2.
- `rsp_valid`  out  1  result/trap available; held until accepted.
- `rsp_ready`  in  1  core accepts response.
- `rsp_wr`  out  1  responder requested register write.
- `rsp_rd`  out  32  result data.
- `rsp_trap`  out  1  no responder claimed instruction.
- `pcpi_valid`  out  1  instruction on bus.
- `pcpi_insn`  out  32  registered copy of `req_insn`.
- `pcpi_rs1`  out  32  registered copy of `req_rs1`.
- `pcpi_rs2`  out  32  registered copy of `req_rs2`.
- `pcpi_wr`  in  1  responder write request, sampled with `pcpi_ready`.
- `pcpi_rd`  in  32  responder result, sampled with `pcpi_ready`.
- `pcpi_wait`  in  1  a responder claims the instruction but needs more time.
- `pcpi_ready`  in  1  responder result valid this cycle.

## Operation
- The FSM has three states: IDLE, ISSUE, RESP. All outputs are registered or decoded from state only; there are no combinational paths from the `pcpi_*` inputs to outputs.
- **IDLE:** `req_ready`=1.
  - On `req_valid`, capture insn/rs1/rs2 into the `pcpi_*` registers.
  - Clear the timeout counter and go to ISSUE.
- **ISSUE:** `pcpi_valid`=1. Operands stay stable for the whole state.
  - `pcpi_ready`=1: capture `pcpi_wr` into `rsp_wr` and `pcpi_rd` into `rsp_rd`, set `rsp_trap`=0, go to RESP.
  - Else if `pcpi_wait`=1: clear the counter and stay. Waiting is unbounded while `pcpi_wait` stays high.
  - Else if counter == `TIMEOUT_CYCLES`-1: set `rsp_trap`=1, `rsp_wr`=0, `rsp_rd`=0, go to RESP.
  - Else: increment the counter (8-bit) and stay.
  - Priority when inputs coincide: ready > wait > timeout.
- **RESP:** `rsp_valid`=1 and the response fields are held. On `rsp_ready`, go to IDLE.
- `pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` keep their last values outside ISSUE. Responders must qualify them with `pcpi_valid`.
- `rsp_wr`/`rsp_rd`/`rsp_trap` keep their last values outside RESP.
- **Reset (asynchronous, any state):**
  - State goes to IDLE; the counter and all registers clear to 0.
  - Outputs while `reset` is high: `pcpi_valid`=0, `rsp_valid`=0, `rsp_wr`=0, `rsp_rd`=0, `rsp_trap`=0, `pcpi_insn`/`pcpi_rs1`/`pcpi_rs2`=0, and `req_ready`=0 (gated by reset).
  - After reset deasserts, `req_ready`=1 on the first cycle.
  - An in-flight instruction is dropped with no response. A `pcpi_ready` arriving after reset is ignored.

## Timing
- Request accepted at edge E0 (`req_valid`&&`req_ready`): `pcpi_valid` is high from E0 until the edge that samples `pcpi_ready`.
- `pcpi_ready` sampled at edge Ek: `pcpi_valid` falls after Ek and `rsp_valid` rises after Ek. The responder sees `pcpi_valid` high in the same cycle it asserts `pcpi_ready`.
- A responder asserting `pcpi_ready` two cycles after `pcpi_valid` rises gives `rsp_valid` three cycles after the request handshake.
- Timeout with no wait/ready: `pcpi_valid` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` with `rsp_trap`=1.
- Response handshake (`rsp_valid`&&`rsp_ready`) at edge R: `req_ready`=1 in the next cycle. A new request is accepted one cycle later at the earliest.
- Minimum repeat interval per instruction = 1 (IDLE) + issue cycles + 1 (RESP).
- `pcpi_wr`/`pcpi_rd` are sampled only in the ISSUE cycle with `pcpi_ready`=1. Values in other cycles are don't-care.

## Test plan
- **Reset values:** assert `reset` mid-ISSUE -> `pcpi_valid`=0 immediately. After deassert, `req_ready`=1 and `rsp_valid`=0. A late `pcpi_ready`=1 produces no response.
- **MUL responder model:** insn=0x02B50533 (mul), rs1=7, rs2=6. Model asserts ready 2 cycles after valid with wr=1, rd=42 -> `rsp_valid` with `rsp_wr`=1, `rsp_rd`=42, `rsp_trap`=0. `pcpi_valid` is high exactly 3 cycles.
- **No responder, `TIMEOUT_CYCLES`=16:** `pcpi_valid` high exactly 16 cycles -> `rsp_trap`=1, `rsp_wr`=0, `rsp_rd`=0.
- **Wait extension:** `pcpi_wait` high for 40 cycles, then ready with rd=0xDEADBEEF -> no trap; `rsp_rd`=0xDEADBEEF.
- **Wait then drop:** `pcpi_wait` high 10 cycles, then low with no ready -> trap after exactly 16 more `pcpi_valid` cycles.
- **Coincident events and backpressure:**
  - `pcpi_ready` in the cycle where counter == 15 -> result accepted, no trap.
  - `rsp_ready` held low 5 cycles -> `rsp_*` stable and `req_ready`=0 throughout.
  - Back-to-back requests -> each issued exactly once, with operands matching their own request.
